// File: rtl/clk_strobe_gen_pkg.sv
// Shared defaults and limits for the programmable clock/strobe divider.
package clk_strobe_gen_pkg;

    localparam int DIV_W_DEF   = 16;
    localparam int RST_DIV_DEF = 2;
    localparam int NUM_CH_MAX  = 16;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_strobe_ch.sv
// One divider channel: active divisor, shadow divisor, phase counter and
// registered strobe / square-wave outputs.
module clk_strobe_ch
    import clk_strobe_gen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int RST_DIV = RST_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] val,
    input  logic             sync,
    output logic             stb,
    output logic             div_clk
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(RST_DIV);

    logic [DIV_W-1:0] n_q;
    logic [DIV_W-1:0] s_q;
    logic [DIV_W-1:0] c_q;
    logic [DIV_W-1:0] s_eff;
    logic [DIV_W-1:0] n_nxt;
    logic [DIV_W-1:0] c_nxt;
    logic             wrap;
    logic             load;

    // A disabled channel (N=0) treats every edge as a period boundary, so a
    // new divisor starts counting from 0 immediately.
    always_comb begin
        s_eff = wr ? val : s_q;
        wrap  = (n_q != '0) && (c_q == n_q - ONE);
        load  = sync || (n_q == '0) || wrap;
        n_nxt = load ? s_eff : n_q;
        c_nxt = load ? '0 : c_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q     <= DIV_INIT;
            s_q     <= DIV_INIT;
            c_q     <= '0;
            stb     <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            n_q     <= n_nxt;
            s_q     <= s_eff;
            c_q     <= c_nxt;
            // A realign restarts the period, so it does not count as a wrap.
            stb     <= (n_nxt == ONE) || (wrap && !sync && (n_nxt != '0));
            div_clk <= c_nxt < (n_nxt >> 1);
        end
    end

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock/strobe generator: write decode, ack and sync fan-out
// around NUM_CH independent divider channels.
module clk_strobe_gen
    import clk_strobe_gen_pkg::*;
#(
    parameter int  NUM_CH  = 3,
    parameter int  DIV_W   = DIV_W_DEF,
    parameter int  RST_DIV = RST_DIV_DEF,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_div_wr,
    input  logic [CH_W-1:0]   i_div_ch,
    input  logic [DIV_W-1:0]  i_div_val,
    output logic              o_div_ack,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_stb,
    output logic [NUM_CH-1:0] o_clk
);

    if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end

    // Write port: i_div_wr is a one-cycle request with no backpressure. Every
    // request whose channel exists is accepted on that edge and answered by a
    // single o_div_ack pulse in the next cycle; others are silently dropped.
    logic              wr_ok;
    logic [NUM_CH-1:0] ch_wr;

    assign wr_ok = i_div_wr && (32'(i_div_ch) < NUM_CH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_div_ack <= 1'b0;
        end else begin
            o_div_ack <= wr_ok;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_wr[k] = wr_ok && (32'(i_div_ch) == k);

        clk_strobe_ch #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr      (ch_wr[k]),
            .val     (i_div_val),
            .sync    (i_sync),
            .stb     (o_stb[k]),
            .div_clk (o_clk[k])
        );
    end

endmodule

// File: doc/clk_strobe_gen.md
CLK_STROBE_GEN -- requirements
Module: clk_strobe_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent divider channels, range 1..16.
REQ-002 Parameter DIV_W, default 16: divisor width in bits.
REQ-003 Parameter RST_DIV, default 2: divisor loaded into every channel at reset, must be below 2**DIV_W.
REQ-004 Port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port i_rst  input  1  reset, synchronous, active-high.
REQ-006 Port i_div_wr  input  1  divisor write strobe, one cycle per write.
REQ-007 Port i_div_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-008 Port i_div_val  input  DIV_W  new divisor N; 0 = channel disabled.
REQ-009 Port o_div_ack  output  1  one-cycle pulse acknowledging an accepted write.
REQ-010 Port i_sync  input  1  realign pulse: restart all channels in phase.
REQ-011 Port o_stb  output  NUM_CH  per-channel one-cycle strobe, once per period.
REQ-012 Port o_clk  output  NUM_CH  per-channel divided square wave, registered.

Function
REQ-013 Each channel holds an active divisor N, a shadow divisor S and a counter c in 0..N-1, with c incrementing each cycle and wrapping from N-1 to 0.
REQ-014 o_stb[k] is registered and high for exactly the one cycle following an edge at which c == N-1, giving period N cycles and one cycle of latency.
REQ-015 o_clk[k] is registered and high while c < N>>1 and low otherwise, giving N=2 an exact clock/2 and odd N a high time of floor(N/2) cycles.
REQ-016 N=1: o_stb[k] is held high continuously and o_clk[k] is held low.
REQ-017 N=0: c is held at 0 and o_stb[k] and o_clk[k] are both held low.
REQ-018 A write with i_div_wr=1 and i_div_ch<NUM_CH loads S of that channel, and o_div_ack pulses on the following cycle.
REQ-019 A write with i_div_ch>=NUM_CH is ignored and produces no o_div_ack.
REQ-020 S transfers to N only at a period boundary, i.e. on the edge where c wraps to 0, so no shortened or glitched period is produced.
REQ-021 If the active N is 0, S transfers to N on the next edge after the write and c starts at 0.
REQ-022 Back-to-back writes to the same channel before a boundary leave the last written value in S (last-write-wins); each write is acknowledged.
REQ-023 i_sync=1 sets every counter c to 0 and copies every S to N on the same edge, and o_stb and o_clk are then evaluated against the new N.
REQ-024 A simultaneous i_sync and write to the same channel uses the newly written value, which is loaded into both S and N.
REQ-025 A simultaneous boundary and write to the same channel uses the newly written value.

Reset
REQ-026 i_rst=1 sets N=S=RST_DIV and c=0 on all channels, and drives o_stb=0, o_clk=0 and o_div_ack=0.
REQ-027 i_rst dominates i_div_wr and i_sync, so a write presented during reset is dropped without an ack.
REQ-028 Reset asserted mid-period aborts that period, and counting restarts from c=0 on the first edge with i_rst=0.

Structure
REQ-029 A shared package holds the DIV_W and RST_DIV defaults and the NUM_CH limit.
REQ-030 One sub-module, clk_strobe_ch, implements a single channel (N, S, c, o_stb and o_clk) and is instantiated NUM_CH times in a generate loop.
REQ-031 The top level holds only write decoding, ack generation and sync fan-out.

Verification
REQ-032 Reset release with RST_DIV=2 -> o_clk[k] toggles every cycle, and o_stb[k] pulses every 2nd cycle with its first pulse one cycle after the first c==1 edge.
REQ-033 Write ch1=5 mid-period of N=2 -> ack one cycle later, the current 2-cycle period completes, then a 5-cycle period with o_clk high 2 and low 3.
REQ-034 Write ch0=0 then ch0=4 -> ch0 outputs stay low after the next boundary, and after the second write counting restarts at once with period 4.
REQ-035 Channels set to N=3, 4 and 6, then i_sync pulsed -> all o_stb coincide every 12 cycles after sync; same-cycle i_sync and write ch2=8 -> ch2 period 8 immediately.
REQ-036 Write to ch=NUM_CH -> no ack and no divisor change; i_rst pulsed mid-period with a write in the same cycle -> all outputs 0, divisors RST_DIV, no ack.
